zxdma_ctrl: RTL
===============

# zxdma_ctrl

Sequencer for ZX-bus DMA into NeoGS memory. It sits between the `zxbus` module (`dmaread`, `dmawrite`, `dma_data_written`, `dma_data_toberead`, `wait_ena`, `dma_on`) and the NGS memory arbiter. It holds the ZX Z80 in /WAIT while it performs one NGS memory access per ZX ROM-window cycle at an auto-incrementing pointer. The pointer and control bits are programmed by the NGS Z80.

## Interface
Parameters:
- ADDR_W, 19: NGS memory pointer width (512 KB).
- TO_W, 8: timeout counter width (used only with ZXDMA_TIMEOUT_EN).

Ports:
- cpu_clock  in  1  NGS clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wr  in  1  one-cycle config write strobe from the NGS port decoder.
- cfg_sel  in  2  register select: 0 = ptr[7:0], 1 = ptr[15:8], 2 = ptr[ADDR_W-1:16], 3 = control/status.
- cfg_din  in  8  config write data.
- cfg_dout  out  8  combinational readback of the register at cfg_sel.
- dma_on  out  1  DMA enable, control bit 0; drives `zxbus.dma_on`.
- dmaread, dmawrite  in  1  asynchronous ZX strobes from `zxbus`.
- dma_data_written  in  8  ZX write data, latched by `zxbus` at the falling edge of `dmawrite`.
- dma_data_toberead  out  8  data presented to the ZX on reads.
- wait_ena  out  1  1 = hold the ZX in /WAIT.
- mem_req  out  1  memory request; held until mem_ack.
- mem_rnw  out  1  1 = read, 0 = write.
- mem_addr  out  ADDR_W  access address (current pointer).
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.

## Operation
- Control register (sel 3):
  - Write: bit0 dma_on, bit1 autoinc.
  - Read: {err, busy, 4'b0, autoinc, dma_on}.
  - busy = FSM not in IDLE.
  - Reading the pointer-high byte returns unused bits as 0.
- dmaread and dmawrite pass through 2-flop synchronizers (rs, ws). If both are high, the write is taken.
- FSM states: IDLE, RD_REQ, RD_HOLD, WR_HOLD, WR_REQ.
  - IDLE: wait_ena = dma_on. On rs → RD_REQ. On ws → WR_HOLD.
  - RD_REQ: mem_req=1, mem_rnw=1, wait_ena=1. On mem_ack: dma_data_toberead ← mem_rdata, step the pointer, go to RD_HOLD.
  - RD_HOLD: wait_ena=0. When rs=0 → IDLE.
  - WR_HOLD: wait_ena=0 (no memory access yet; the data is not latched until the ZX cycle ends). When ws=0 → WR_REQ.
  - WR_REQ: mem_req=1, mem_rnw=0, mem_wdata=dma_data_written, wait_ena=1 (a following ZX access is stalled). On mem_ack: step the pointer, go to IDLE.
- Pointer step: +1 if autoinc, else hold. Wraps from 2^ADDR_W-1 to 0.
- A cfg pointer write in the same cycle as a step wins; it applies only to the selected byte.
- Clearing dma_on mid-operation:
  - wait_ena is forced to 0 immediately.
  - An outstanding mem_req still completes; mem_req never drops before mem_ack, except on timeout.
  - The HOLD states exit normally because `zxbus` gates the strobes with dma_on.
- Reset values: dma_on 0, autoinc 0, pointer 0, wait_ena 0, mem_req 0, mem_rnw 1, mem_wdata 0, dma_data_toberead 8'hFF, err 0, FSM IDLE. Reset mid-transaction drops mem_req immediately.

## Timing
- All outputs are registered except cfg_dout.
- Read: dmaread rises before edge 0.
  - rs = 1 after edge 1.
  - RD_REQ is entered, with mem_req=1, after edge 2.
  - If mem_ack arrives in cycle k, wait_ena=0 and the data are valid after edge k+1.
- Write:
  - WR_HOLD, with wait_ena=0, is entered 2 edges after dmawrite rises.
  - mem_req asserts 2 edges after dmawrite falls.
- Minimum RD_REQ/WR_REQ duration is 1 cycle (ack in the first request cycle).
- The FSM returns to IDLE and re-arms wait_ena 2 edges after the strobe falls (reads) or on the edge after mem_ack (writes).

## Configuration
- ZXDMA_TIMEOUT_EN defined:
  - A TO_W-bit counter runs in RD_REQ and WR_REQ.
  - If 2^TO_W-1 cycles pass without mem_ack: mem_req drops, err (sticky) is set, and the FSM behaves as if acked.
  - On a read timeout, the data is 8'hFF.
  - The pointer still steps.
  - err is cleared by writing control with bit7=1.
- ZXDMA_TIMEOUT_EN undefined: no counter, the FSM waits indefinitely, and err reads 0.

## Structure
- zxdma_pkg:
  - state encoding;
  - cfg_sel constants (SEL_PTRL, SEL_PTRM, SEL_PTRH, SEL_CTRL);
  - control bit indices;
  - the 8'hFF idle-data constant.
- One sub-module, zxdma_sync: a 2-flop synchronizer, instantiated for dmaread and dmawrite, reset to 0.

## Test plan
- Read with autoinc: ptr=19'h12345, dma_on=1, autoinc=1, pulse dmaread; arbiter acks 3 cycles after mem_req with 8'hA5 → mem_addr=19'h12345, dma_data_toberead=8'hA5, wait_ena falls the edge after ack, ptr=19'h12346.
- Write: pulse dmawrite with data 8'h3C → wait_ena=0 within 2 edges; after the strobe falls, mem_req asserts with mem_rnw=0, mem_wdata=8'h3C, addr = ptr.
- Wrap and autoinc off: ptr=19'h7FFFF, autoinc=1, one read → ptr=0. Then autoinc=0, two reads → ptr stays 0.
- Collision: a cfg write to SEL_PTRL=8'h10 in the same cycle as mem_ack → ptr[7:0]=8'h10, no increment.
- dma_on cleared during RD_REQ → wait_ena=0 next edge, mem_req held until ack, FSM returns to IDLE. Reset asserted during WR_REQ → all outputs at reset values.
- ZXDMA_TIMEOUT_EN, TO_W=4, no ack → mem_req drops after 15 cycles, err=1, data 8'hFF; a control write with bit7=1 clears err.

Source files
------------

// File: rtl/zxdma_pkg.sv
// rtl/zxdma_pkg.sv - shared state encoding, register selects and constants for the ZX DMA sequencer
package zxdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_WR_HOLD = 3'd3,
        ST_WR_REQ  = 3'd4
    } state_e;

    localparam logic [1:0] SEL_PTRL = 2'd0;
    localparam logic [1:0] SEL_PTRM = 2'd1;
    localparam logic [1:0] SEL_PTRH = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    localparam int CTRL_DMA_ON  = 0;
    localparam int CTRL_AUTOINC = 1;
    localparam int CTRL_BUSY    = 6;
    localparam int CTRL_ERR     = 7;

    localparam logic [7:0] IDLE_DATA = 8'hFF;

endpackage

// File: rtl/zxdma_sync.sv
// rtl/zxdma_sync.sv - two-flop synchronizer for the asynchronous ZX strobes
module zxdma_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/zxdma_ctrl.sv
// rtl/zxdma_ctrl.sv - ZX-bus DMA sequencer into NGS memory (optional ZXDMA_TIMEOUT_EN adds a request timeout)
module zxdma_ctrl
    import zxdma_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int TO_W   = 8
) (
    input  logic              cpu_clock,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_sel,
    input  logic [7:0]        cfg_din,
    output logic [7:0]        cfg_dout,
    output logic              dma_on,
    input  logic              dmaread,
    input  logic              dmawrite,
    input  logic [7:0]        dma_data_written,
    output logic [7:0]        dma_data_toberead,
    output logic              wait_ena,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              dma_on_q, dma_on_d;
    logic              autoinc_q, autoinc_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic              rnw_q, rnw_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rs, ws;
    logic              step;
    logic              timeout;
    logic              err;
    logic              in_req;

    zxdma_sync u_sync_rd (.clk(cpu_clock), .rst_n(rst_n), .d_i(dmaread),  .q_o(rs));
    zxdma_sync u_sync_wr (.clk(cpu_clock), .rst_n(rst_n), .d_i(dmawrite), .q_o(ws));

    assign in_req = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);

`ifdef ZXDMA_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // Last counted cycle without an ack ends the request as if it had been acked
    assign timeout = in_req && !mem_ack && (to_cnt_q == TO_LAST);
    assign err     = err_q;

    // Request-duration counter, cleared whenever no request is waiting
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (in_req && !mem_ack && !timeout) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Sticky error flag: set on timeout, cleared by a control write with bit 7 set
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (cfg_wr && (cfg_sel == SEL_CTRL) && cfg_din[CTRL_ERR]) begin
            err_q <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of every registered output, derived from the state being entered
    always_comb begin
        state_d   = state_q;
        step      = 1'b0;
        dma_on_d  = dma_on_q;
        autoinc_d = autoinc_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        ptr_d     = ptr_q;

        if (cfg_wr && (cfg_sel == SEL_CTRL)) begin
            dma_on_d  = cfg_din[CTRL_DMA_ON];
            autoinc_d = cfg_din[CTRL_AUTOINC];
        end

        case (state_q)
            ST_IDLE: begin
                if (ws) begin
                    state_d = ST_WR_HOLD;
                end else if (rs) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mem_ack || timeout) begin
                    step    = 1'b1;
                    rdata_d = mem_ack ? mem_rdata : IDLE_DATA;
                    state_d = ST_RD_HOLD;
                end
            end
            ST_RD_HOLD: begin
                if (!rs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_HOLD: begin
                // The ZX write data is only stable once its strobe has gone away
                if (!ws) begin
                    wdata_d = dma_data_written;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (mem_ack || timeout) begin
                    step    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step && autoinc_q) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end

        // A pointer write from the NGS side overrides a same-cycle step
        if (cfg_wr) begin
            case (cfg_sel)
                SEL_PTRL: begin
                    ptr_d      = ptr_q;
                    ptr_d[7:0] = cfg_din;
                end
                SEL_PTRM: begin
                    ptr_d       = ptr_q;
                    ptr_d[15:8] = cfg_din;
                end
                SEL_PTRH: begin
                    ptr_d              = ptr_q;
                    ptr_d[ADDR_W-1:16] = cfg_din[ADDR_W-17:0];
                end
                default: ;
            endcase
        end

        req_d  = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        rnw_d  = (state_d != ST_WR_REQ);
        wait_d = dma_on_d && ((state_d == ST_IDLE) || req_d);
    end

    // Pointer, control bits and registered outputs
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            dma_on_q  <= 1'b0;
            autoinc_q <= 1'b0;
            wait_q    <= 1'b0;
            req_q     <= 1'b0;
            rnw_q     <= 1'b1;
            wdata_q   <= 8'h00;
            rdata_q   <= IDLE_DATA;
        end else begin
            ptr_q     <= ptr_d;
            dma_on_q  <= dma_on_d;
            autoinc_q <= autoinc_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            rnw_q     <= rnw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Combinational register readback
    always_comb begin
        case (cfg_sel)
            SEL_PTRL: cfg_dout = ptr_q[7:0];
            SEL_PTRM: cfg_dout = ptr_q[15:8];
            SEL_PTRH: cfg_dout = 8'(ptr_q[ADDR_W-1:16]);
            default:  cfg_dout = {err, (state_q != ST_IDLE), 4'b0000, autoinc_q, dma_on_q};
        endcase
    end

    assign dma_on            = dma_on_q;
    assign wait_ena          = wait_q;
    assign mem_req           = req_q;
    assign mem_rnw           = rnw_q;
    assign mem_addr          = ptr_q;
    assign mem_wdata         = wdata_q;
    assign dma_data_toberead = rdata_q;

endmodule
